// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake on both sides and an NZVC flag register.
// Define ALU_PIPE_MUL_EN to make cntrl 111 an iterative unsigned multiply; otherwise 111 is reserved.
module alu_pipe #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       cntrl,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic [3:0]       flags_q
);

    logic             busy;
    logic             mul_op;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] alu_r;
    logic             alu_v;
    logic             alu_c;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = !busy && slot_free;
    assign accept    = in_valid && in_ready;

    // Single-cycle operations; subtraction is a + ~b + 1 so its carry means no-borrow.
    always_comb begin
        add_w = {1'b0, a} + {1'b0, b};
        sub_w = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        alu_r = '0;
        alu_v = 1'b0;
        alu_c = 1'b0;
        case (cntrl)
            3'b000: alu_r = b;
            3'b010: begin
                alu_r = add_w[WIDTH-1:0];
                alu_c = add_w[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            3'b011: begin
                alu_r = sub_w[WIDTH-1:0];
                alu_c = sub_w[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            3'b100:  alu_r = a & b;
            3'b101:  alu_r = a | b;
            3'b110:  alu_r = a ^ b;
            default: alu_r = '0;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mul_r;
    logic [CW-1:0]    cnt;
    logic             mul_setf;
    logic             mul_done;

    assign busy     = (state == MUL);
    assign mul_op   = (cntrl == 3'b111);
    // The last partial product is folded into the load so busy lasts exactly WIDTH cycles.
    assign mul_r    = acc + (mplier[0] ? mcand : '0);
    assign mul_done = busy && (cnt == CW'(WIDTH-1)) && slot_free;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            mul_setf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && mul_op) begin
                        state    <= MUL;
                        acc      <= '0;
                        mcand    <= a;
                        mplier   <= b;
                        cnt      <= '0;
                        mul_setf <= set_flags;
                    end
                end
                MUL: begin
                    if (cnt != CW'(WIDTH-1)) begin
                        acc    <= mul_r;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end else if (slot_free) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign busy   = 1'b0;
    assign mul_op = 1'b0;
`endif

    // Output slot: pop clears it, a new accept (or multiply completion) refills it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
            flags_q   <= 4'b0000;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !mul_op) begin
                out_valid <= 1'b1;
                result    <= alu_r;
                negative  <= alu_r[WIDTH-1];
                zero      <= (alu_r == '0);
                overflow  <= alu_v;
                carry_out <= alu_c;
                if (set_flags) begin
                    flags_q <= {alu_r[WIDTH-1], (alu_r == '0), alu_v, alu_c};
                end
            end
`ifdef ALU_PIPE_MUL_EN
            if (mul_done) begin
                out_valid <= 1'b1;
                result    <= mul_r;
                negative  <= mul_r[WIDTH-1];
                zero      <= (mul_r == '0);
                overflow  <= 1'b0;
                carry_out <= 1'b0;
                if (mul_setf) begin
                    flags_q <= {mul_r[WIDTH-1], (mul_r == '0), 2'b00};
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: 64-bit instance under random back-pressure plus an 8-bit instance.
// Multiply checks are compiled in only when ALU_PIPE_MUL_EN is defined.
module tb_alu_pipe;

    typedef struct packed {
        logic [63:0] r;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
    } res_t;

    typedef struct packed {
        res_t       res;
        logic [3:0] fl;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready, set_flags, out_valid, out_ready;
    logic [63:0] a, b, result;
    logic [2:0]  cntrl;
    logic        negative, zero, overflow, carry_out;
    logic [3:0]  flags_q;

    logic        iv8, ir8, sf8, ov8, or8;
    logic [7:0]  a8, b8, r8;
    logic [2:0]  c8;
    logic        n8, z8, v8, co8;
    logic [3:0]  fq8;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   pushed = 0, popped = 0, dropped = 0;
    logic [3:0] mflags = 4'b0000;
    int   bp_mode = 0;

    alu_pipe #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cntrl(cntrl), .set_flags(set_flags),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .negative(negative), .zero(zero), .overflow(overflow),
        .carry_out(carry_out), .flags_q(flags_q)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cntrl(c8), .set_flags(sf8),
        .out_valid(ov8), .out_ready(or8), .result(r8),
        .negative(n8), .zero(z8), .overflow(v8),
        .carry_out(co8), .flags_q(fq8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_mul(input logic [2:0] op);
`ifdef ALU_PIPE_MUL_EN
        return op == 3'b111;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: plain unsigned/signed arithmetic on values of width w.
    function automatic res_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                   input logic [2:0] op);
        res_t              e;
        logic [63:0]       mask;
        logic [65:0]       us;
        logic signed [66:0] two_w, sx, sy, s, hi, lo;
        mask  = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        x     = x & mask;
        y     = y & mask;
        two_w = 67'sd1 <<< w;
        hi    = (two_w >>> 1) - 67'sd1;
        lo    = -(two_w >>> 1);
        sx    = $signed({3'b000, x});
        sy    = $signed({3'b000, y});
        if (x[w-1]) sx = sx - two_w;
        if (y[w-1]) sy = sy - two_w;
        e = '0;
        case (op)
            3'b000: e.r = y;
            3'b010: begin
                us  = {2'b00, x} + {2'b00, y};
                e.r = us[63:0] & mask;
                e.c = us > {2'b00, mask};
                s   = sx + sy;
                e.v = (s > hi) || (s < lo);
            end
            3'b011: begin
                e.r = (x - y) & mask;
                e.c = x >= y;
                s   = sx - sy;
                e.v = (s > hi) || (s < lo);
            end
            3'b100: e.r = x & y;
            3'b101: e.r = x | y;
            3'b110: e.r = x ^ y;
            3'b111: e.r = is_mul(op) ? ((x * y) & mask) : 64'd0;
            default: e.r = 64'd0;
        endcase
        e.n = e.r[w-1];
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // out_ready changes only at posedge+2 so negedge sampling never races it.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: every handshake-completed output is compared with the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got result %0h with empty scoreboard", result);
                end else begin
                    mon_e = sb.pop_front();
                    popped++;
                    chk("result", result, mon_e.res.r);
                    chk("nzvc", {60'd0, negative, zero, overflow, carry_out},
                        {60'd0, mon_e.res.n, mon_e.res.z, mon_e.res.v, mon_e.res.c});
                    chk("flags_q", {60'd0, flags_q}, {60'd0, mon_e.fl});
                end
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y,
                         input logic sf);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        cntrl     = op;
        set_flags = sf;
    endtask

    // Called at a negedge with inputs driven; returns at posedge+1 after the accept edge.
    task automatic wait_accept(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y,
                               input logic sf, output int waited);
        exp_t e;
        waited = 0;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready %0b after %0d cycles, required 1", in_ready, waited);
            in_valid = 1'b0;
        end else begin
            e.res = model(64, x, y, op);
            if (sf) mflags = {e.res.n, e.res.z, e.res.v, e.res.c};
            e.fl = mflags;
            sb.push_back(e);
            pushed++;
            @(posedge clk);
            #1;
            if (!is_mul(op)) chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y,
                         input logic sf);
        int w;
        @(negedge clk);
        drive(op, x, y, sf);
        wait_accept(op, x, y, sf, w);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic t8(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        res_t e;
        @(negedge clk);
        iv8 = 1'b1; a8 = x; b8 = y; c8 = op; sf8 = 1'b1;
        chk("w8_in_ready", {63'd0, ir8}, 64'd1);
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        e = model(8, {56'd0, x}, {56'd0, y}, op);
        chk("w8_out_valid", {63'd0, ov8}, 64'd1);
        chk("w8_result", {56'd0, r8}, e.r);
        chk("w8_nzvc", {60'd0, n8, z8, v8, co8}, {60'd0, e.n, e.z, e.v, e.c});
        chk("w8_flags_q", {60'd0, fq8}, {60'd0, e.n, e.z, e.v, e.c});
    endtask

    initial begin
        int          w;
        int          cyc;
        logic [63:0] held;
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cntrl = '0; set_flags = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; c8 = '0; sf8 = 1'b0; or8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_flags_q", {60'd0, flags_q}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_w8_out_valid", {63'd0, ov8}, 64'd0);

        // Directed corner cases, back to back
        issue(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        issue(3'b011, 64'd5, 64'd5, 1'b1);
        chk("sub_flags_q", {60'd0, flags_q}, 64'h5);
        issue(3'b110, 64'hF0F0, 64'h0FF0, 1'b0);
        chk("xor_keeps_flags_q", {60'd0, flags_q}, 64'h5);
        issue(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        issue(3'b011, 64'd0, 64'd1, 1'b1);
        issue(3'b011, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        issue(3'b000, 64'd3, 64'hDEAD_BEEF, 1'b1);
        issue(3'b001, 64'd3, 64'd4, 1'b1);
        issue(3'b100, 64'hFF00, 64'h0FF0, 1'b0);
        issue(3'b101, 64'hFF00, 64'h0FF0, 1'b0);
        issue(3'b111, 64'd7, 64'd9, 1'b1);
        idle();

        // 8-bit instance
        t8(3'b010, 8'hFF, 8'h01);
        t8(3'b010, 8'h7F, 8'h01);
        t8(3'b011, 8'h80, 8'h01);
        for (int i = 0; i < 12; i++) begin
            t8(3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));
        end

        // Random traffic under random back-pressure
        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom_range(0, 7)), rnd64(), rnd64(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                idle();
                @(posedge clk);
            end
        end
        idle();
        bp_mode = 0;
        cyc = 0;
        while (sb.size() != 0 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        repeat (2) @(posedge clk);

        // Held output: three stalled cycles, then release
        issue(3'b010, 64'd100, 64'd23, 1'b0);
        bp_mode = 2;
        @(negedge clk);
        drive(3'b011, 64'd50, 64'd8, 1'b0);
        held = result;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_result_hold", result, held);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            @(negedge clk);
        end
        bp_mode = 0;
        @(negedge clk);
        wait_accept(3'b011, 64'd50, 64'd8, 1'b0, w);
        chk("bp_release_accept_wait", 64'(w), 64'd0);
        idle();
        repeat (2) @(posedge clk);

        // Reset while the output slot is full
        issue(3'b010, 64'd3, 64'd4, 1'b1);
        idle();
        bp_mode = 2;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flags_q", {60'd0, flags_q}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_result", result, 64'd0);
        dropped += sb.size();
        sb.delete();
        mflags  = 4'b0000;
        bp_mode = 0;
        repeat (2) @(posedge clk);

`ifdef ALU_PIPE_MUL_EN
        // Multiply timing: busy for 64 cycles, result valid in the following one
        issue(3'b111, 64'd12, 64'd13, 1'b0);
        idle();
        cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", 64'(cyc), 64'd64);
        chk("mul_out_valid", {63'd0, out_valid}, 64'd1);
        chk("mul_result", result, 64'd156);
        chk("mul_nz", {62'd0, negative, zero}, 64'd0);
        repeat (2) @(posedge clk);

        // Reset in the middle of a multiply aborts it
        issue(3'b111, 64'd5, 64'd6, 1'b1);
        idle();
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        dropped += sb.size();
        sb.delete();
        mflags = 4'b0000;
        chk("mulrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mulrst_flags_q", {60'd0, flags_q}, 64'd0);
        cyc = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) cyc++;
        end
        chk("mulrst_no_output", 64'(cyc), 64'd0);
`endif

        idle();
        cyc = 0;
        while (sb.size() != 0 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("no_loss_or_dup", 64'(popped), 64'(pushed - dropped));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
